// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the registered ALU-operation controller: ALUOp classes,
// 4-bit operation codes, FSM states and the base decode table.
package alu_ctrl_pkg;

    typedef enum logic [1:0] {
        ALUOP_MEM    = 2'b00,
        ALUOP_BRANCH = 2'b01,
        ALUOP_RI     = 2'b10,
        ALUOP_JUMP   = 2'b11
    } aluop_e;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0011;
    localparam logic [3:0] OP_BEQ = 4'b0101;
    localparam logic [3:0] OP_BNE = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_BLT = 4'b0111;
    localparam logic [3:0] OP_BGE = 4'b1000;
    localparam logic [3:0] OP_LUI = 4'b1100;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_MEXT = 7'b0000001;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        VALID = 2'b01,
        MULTI = 2'b10
    } state_e;

    // Base RV32I table; unlisted combinations fall back to the AND code.
    function automatic logic [3:0] base_decode(input logic [1:0] alu_op,
                                               input logic [6:0] funct7,
                                               input logic [2:0] funct3);
        logic [3:0] code;
        code = OP_AND;
        case (alu_op)
            ALUOP_MEM:  code = OP_ADD;
            ALUOP_JUMP: code = OP_LUI;
            ALUOP_BRANCH: begin
                case (funct3)
                    3'b000:  code = OP_BEQ;
                    3'b001:  code = OP_BNE;
                    3'b100:  code = OP_BLT;
                    3'b101:  code = OP_BGE;
                    default: code = OP_AND;
                endcase
            end
            default: begin
                case (funct3)
                    3'b000:  code = OP_ADD;
                    3'b010:  code = OP_SLT;
                    3'b100:  code = (funct7 == F7_BASE) ? OP_XOR : OP_AND;
                    3'b110:  code = (funct7 == F7_BASE) ? OP_OR  : OP_AND;
                    default: code = OP_AND;
                endcase
            end
        endcase
        return code;
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational ALUOp/Funct7/Funct3 decoder with a multi-cycle flag.
// M-extension decode is present only when ALU_CTRL_MEXT_EN is defined.
module alu_op_decode
    import alu_ctrl_pkg::*;
#(
    parameter int OP_W = 5
) (
    input  logic [1:0]      alu_op,
    input  logic [6:0]      funct7,
    input  logic [2:0]      funct3,
    output logic [OP_W-1:0] op_code,
    output logic            is_multi
);

    always_comb begin
        op_code      = '0;
        is_multi     = 1'b0;
        op_code[3:0] = base_decode(alu_op, funct7, funct3);
`ifdef ALU_CTRL_MEXT_EN
        // Funct3[2] selects DIV/DIVU/REM/REMU, which take the sequenced path.
        if (alu_op == ALUOP_RI && funct7 == F7_MEXT) begin
            op_code[4:0] = {2'b10, funct3};
            is_multi     = funct3[2];
        end
`endif
    end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Registered, handshaked ALU-operation controller with flush and retire counter.
// Define ALU_CTRL_MEXT_EN to enable M-extension decode and multi-cycle DIV/REM.
module alu_ctrl_seq
    import alu_ctrl_pkg::*;
#(
    parameter int OP_W        = 5,
    parameter int MDIV_CYCLES = 8,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       ALUOp,
    input  logic [6:0]       Funct7,
    input  logic [2:0]       Funct3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OP_W-1:0]  Operation,
    output logic             busy,
    output logic [CNT_W-1:0] retired_cnt
);

    localparam int CD_W = (MDIV_CYCLES > 1) ? $clog2(MDIV_CYCLES) : 1;
    localparam logic [CD_W-1:0] CD_LOAD = CD_W'(MDIV_CYCLES - 1);

    state_e            state_q, state_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [CD_W-1:0]   cd_q, cd_d;
    logic [CNT_W-1:0]  retired_q, retired_d;

    logic [OP_W-1:0]   dec_op;
    logic              dec_multi;
    logic              accept;
    logic              handshake;

    alu_op_decode #(.OP_W(OP_W)) u_decode (
        .alu_op   (ALUOp),
        .funct7   (Funct7),
        .funct3   (Funct3),
        .op_code  (dec_op),
        .is_multi (dec_multi)
    );

    assign in_ready    = !flush && (state_q == IDLE || (state_q == VALID && out_ready));
    assign accept      = in_valid && in_ready;
    assign out_valid   = (state_q == VALID);
    assign handshake   = out_valid && out_ready;
    assign Operation   = op_q;
    assign retired_cnt = retired_q;

`ifdef ALU_CTRL_MEXT_EN
    assign busy = (state_q == MULTI);
`else
    assign busy = 1'b0;
`endif

    // accept is only possible in IDLE or in VALID with out_ready, so loading a
    // new op covers both the idle start and the back-to-back reload.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cd_d      = cd_q;
        retired_d = retired_q + CNT_W'(handshake);
        if (flush) begin
            state_d = IDLE;
            cd_d    = '0;
        end else if (accept) begin
            op_d = dec_op;
            if (dec_multi) begin
                state_d = MULTI;
                cd_d    = CD_LOAD;
            end else begin
                state_d = VALID;
            end
        end else begin
            case (state_q)
                IDLE: state_d = IDLE;
                VALID: begin
                    if (out_ready) state_d = IDLE;
                end
                MULTI: begin
                    if (cd_q == '0) state_d = VALID;
                    else            cd_d    = cd_q - CD_W'(1);
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            op_q      <= '0;
            cd_q      <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cd_q      <= cd_d;
            retired_q <= retired_d;
        end
    end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed self-checking bench for alu_ctrl_seq; M-extension vectors run only
// when ALU_CTRL_MEXT_EN is defined.
module tb_alu_ctrl_seq;

    localparam int OP_W  = 5;
    localparam int MDIV  = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       ALUOp;
    logic [6:0]       Funct7;
    logic [2:0]       Funct3;
    logic             out_valid;
    logic             out_ready;
    logic [OP_W-1:0]  Operation;
    logic             busy;
    logic [CNT_W-1:0] retired_cnt;

    int vectorCount = 0;
    int missCount   = 0;

    always #5 clk = ~clk;

    alu_ctrl_seq #(.OP_W(OP_W), .MDIV_CYCLES(MDIV), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .ALUOp       (ALUOp),
        .Funct7      (Funct7),
        .Funct3      (Funct3),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .Operation   (Operation),
        .busy        (busy),
        .retired_cnt (retired_cnt)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectorCount++;
        if (got !== want) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [1:0] op, input logic [6:0] f7,
                                 input logic [2:0] f3, input logic ordy);
        in_valid  = v;
        ALUOp     = op;
        Funct7    = f7;
        Funct3    = f3;
        out_ready = ordy;
        #1;
    endtask

    task automatic doReset();
        reset = 1'b1;
        flush = 1'b0;
        applyStimulus(1'b0, 2'b00, 7'h00, 3'b000, 1'b0);
        tick();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        doReset();
        checkOutput("reset out_valid", out_valid, 0);
        checkOutput("reset Operation", Operation, 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset retired", retired_cnt, 0);
        checkOutput("reset in_ready", in_ready, 1);

        // reset while an op is held in VALID
        applyStimulus(1'b1, 2'b01, 7'h00, 3'b001, 1'b0);
        tick();
        applyStimulus(1'b0, 2'b00, 7'h00, 3'b000, 1'b0);
        checkOutput("held before reset", out_valid, 1);
        doReset();
        checkOutput("reset-valid out_valid", out_valid, 0);
        checkOutput("reset-valid Operation", Operation, 0);

`ifdef ALU_CTRL_MEXT_EN
        // reset mid-MULTI with counter at 3
        applyStimulus(1'b1, 2'b10, 7'b0000001, 3'b100, 1'b0);
        tick();
        applyStimulus(1'b0, 2'b00, 7'h00, 3'b000, 1'b0);
        repeat (4) tick();
        checkOutput("multi before reset busy", busy, 1);
        doReset();
        checkOutput("reset-multi busy", busy, 0);
        checkOutput("reset-multi out_valid", out_valid, 0);
        checkOutput("reset-multi retired", retired_cnt, 0);
        checkOutput("reset-multi in_ready", in_ready, 1);
`endif

        // BGE then XOR with non-zero Funct7
        applyStimulus(1'b1, 2'b01, 7'h00, 3'b101, 1'b1);
        checkOutput("bge in_ready", in_ready, 1);
        tick();
        applyStimulus(1'b0, 2'b00, 7'h00, 3'b000, 1'b1);
        checkOutput("bge Operation", Operation, 5'b01000);
        checkOutput("bge out_valid", out_valid, 1);
        tick();
        checkOutput("bge drained", out_valid, 0);
        checkOutput("bge retired", retired_cnt, 1);
        applyStimulus(1'b1, 2'b10, 7'b0100000, 3'b100, 1'b1);
        tick();
        applyStimulus(1'b0, 2'b00, 7'h00, 3'b000, 1'b1);
        checkOutput("xor f7 Operation", Operation, 5'b00000);
        checkOutput("xor f7 out_valid", out_valid, 1);
        tick();
        checkOutput("xor retired", retired_cnt, 2);

        // SLT with M-ext Funct7: base SLT, or MULHSU when M-ext is enabled
        applyStimulus(1'b1, 2'b10, 7'b0000001, 3'b010, 1'b1);
        tick();
`ifdef ALU_CTRL_MEXT_EN
        checkOutput("f7=1 f3=010 Operation", Operation, 5'b10010);
`else
        checkOutput("f7=1 f3=010 Operation", Operation, 5'b00111);
`endif
        checkOutput("f7=1 f3=010 busy", busy, 0);

        // back-to-back chain through unlisted encodings
        applyStimulus(1'b1, 2'b00, 7'h00, 3'b111, 1'b1);
        tick();
        checkOutput("mem ADD Operation", Operation, 5'b00011);
        applyStimulus(1'b1, 2'b10, 7'h00, 3'b001, 1'b1);
        tick();
        checkOutput("ri f3=001 Operation", Operation, 5'b00000);
        applyStimulus(1'b1, 2'b11, 7'h00, 3'b000, 1'b1);
        tick();
        checkOutput("lui Operation", Operation, 5'b01100);
        applyStimulus(1'b1, 2'b01, 7'h00, 3'b010, 1'b1);
        tick();
        checkOutput("branch f3=010 Operation", Operation, 5'b00000);
        applyStimulus(1'b0, 2'b00, 7'h00, 3'b000, 1'b1);
        tick();
        checkOutput("chain retired", retired_cnt, 7);

        // back-to-back ADD, BEQ, LUI
        doReset();
        applyStimulus(1'b1, 2'b00, 7'h00, 3'b000, 1'b1);
        tick();
        applyStimulus(1'b1, 2'b01, 7'h00, 3'b000, 1'b1);
        checkOutput("b2b in_ready", in_ready, 1);
        checkOutput("b2b op1", Operation, 5'b00011);
        tick();
        applyStimulus(1'b1, 2'b11, 7'h00, 3'b000, 1'b1);
        checkOutput("b2b op2", Operation, 5'b00101);
        tick();
        applyStimulus(1'b0, 2'b00, 7'h00, 3'b000, 1'b1);
        checkOutput("b2b op3", Operation, 5'b01100);
        checkOutput("b2b op3 valid", out_valid, 1);
        tick();
        checkOutput("b2b retired", retired_cnt, 3);
        checkOutput("b2b drained", out_valid, 0);

        // BNE held under back-pressure for 4 clocks
        doReset();
        applyStimulus(1'b1, 2'b01, 7'h00, 3'b001, 1'b0);
        tick();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 2'b11, 7'h00, 3'b000, 1'b0);
            checkOutput($sformatf("hold%0d in_ready", i), in_ready, 0);
            checkOutput($sformatf("hold%0d Operation", i), Operation, 5'b00110);
            checkOutput($sformatf("hold%0d out_valid", i), out_valid, 1);
            tick();
        end
        applyStimulus(1'b0, 2'b00, 7'h00, 3'b000, 1'b1);
        checkOutput("hold no early retire", retired_cnt, 0);
        tick();
        checkOutput("hold release valid", out_valid, 0);
        checkOutput("hold release retired", retired_cnt, 1);
        applyStimulus(1'b0, 2'b00, 7'h00, 3'b000, 1'b0);
        tick();
        checkOutput("hold single handshake", retired_cnt, 1);

        // flush in VALID with in_valid=1 and out_ready=0
        doReset();
        applyStimulus(1'b1, 2'b10, 7'h00, 3'b110, 1'b0);
        tick();
        checkOutput("or Operation", Operation, 5'b00001);
        flush = 1'b1;
        applyStimulus(1'b1, 2'b01, 7'h00, 3'b000, 1'b0);
        checkOutput("flush in_ready", in_ready, 0);
        tick();
        flush = 1'b0;
        applyStimulus(1'b0, 2'b00, 7'h00, 3'b000, 1'b0);
        checkOutput("flush valid", out_valid, 0);
        checkOutput("flush retired", retired_cnt, 0);
        tick();
        checkOutput("flush input dropped", out_valid, 0);

        // flush in VALID coinciding with a handshake
        applyStimulus(1'b1, 2'b10, 7'h00, 3'b010, 1'b0);
        tick();
        flush = 1'b1;
        applyStimulus(1'b1, 2'b00, 7'h00, 3'b000, 1'b1);
        tick();
        flush = 1'b0;
        applyStimulus(1'b0, 2'b00, 7'h00, 3'b000, 1'b0);
        checkOutput("flush+hs valid", out_valid, 0);
        checkOutput("flush+hs retired", retired_cnt, 1);

`ifdef ALU_CTRL_MEXT_EN
        // flush during MULTI
        doReset();
        applyStimulus(1'b1, 2'b10, 7'b0000001, 3'b101, 1'b0);
        tick();
        applyStimulus(1'b0, 2'b00, 7'h00, 3'b000, 1'b0);
        tick();
        checkOutput("multi busy", busy, 1);
        flush = 1'b1;
        applyStimulus(1'b1, 2'b00, 7'h00, 3'b000, 1'b1);
        tick();
        flush = 1'b0;
        applyStimulus(1'b0, 2'b00, 7'h00, 3'b000, 1'b0);
        checkOutput("flush multi busy", busy, 0);
        checkOutput("flush multi valid", out_valid, 0);
        tick();
        checkOutput("flush multi stays idle", out_valid, 0);

        // DIV latency and MUL single-cycle
        doReset();
        applyStimulus(1'b1, 2'b10, 7'b0000001, 3'b100, 1'b1);
        tick();
        applyStimulus(1'b0, 2'b00, 7'h00, 3'b000, 1'b1);
        for (int i = 0; i < MDIV; i++) begin
            checkOutput($sformatf("div cyc%0d busy", i), busy, 1);
            checkOutput($sformatf("div cyc%0d valid", i), out_valid, 0);
            tick();
        end
        checkOutput("div out_valid", out_valid, 1);
        checkOutput("div busy done", busy, 0);
        checkOutput("div Operation", Operation, 5'b10100);
        tick();
        checkOutput("div retired", retired_cnt, 1);
        applyStimulus(1'b1, 2'b10, 7'b0000001, 3'b000, 1'b1);
        tick();
        applyStimulus(1'b0, 2'b00, 7'h00, 3'b000, 1'b1);
        checkOutput("mul Operation", Operation, 5'b10000);
        checkOutput("mul valid", out_valid, 1);
        checkOutput("mul busy", busy, 0);
        tick();
`else
        // DIV encoding without M-ext is a single-cycle base op
        doReset();
        applyStimulus(1'b1, 2'b10, 7'b0000001, 3'b100, 1'b1);
        tick();
        applyStimulus(1'b0, 2'b00, 7'h00, 3'b000, 1'b1);
        checkOutput("base div-enc valid", out_valid, 1);
        checkOutput("base div-enc busy", busy, 0);
        checkOutput("base div-enc Operation", Operation, 5'b00000);
        tick();
`endif

        // retired counter wrap at 2^CNT_W
        doReset();
        applyStimulus(1'b1, 2'b00, 7'h00, 3'b000, 1'b1);
        repeat (16) tick();
        checkOutput("wrap pre", retired_cnt, 15);
        applyStimulus(1'b0, 2'b00, 7'h00, 3'b000, 1'b1);
        tick();
        checkOutput("wrap to zero", retired_cnt, 0);
        checkOutput("wrap drained", out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
